// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared widths, display geometry and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int c_ADDR_W  = 20;
    localparam int c_DATA_W  = 16;
    localparam int c_H_DISP  = 640;
    localparam int c_COORD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vga_wr_fifo
// Brief    : Power-of-two write buffer; full is taken from the registered count.
// Revision : 1.0
// ============================================================================
module vga_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    // A pop while full never frees a slot for a same-cycle push.
    assign o_full    = (count_q == c_CNT_W'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = mem_q[rd_ptr_q];
    assign o_count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_push_ok && !w_pop_ok) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            count_d = count_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_mem_arbiter
// Brief    : Single-port SRAM arbiter; display reads win, client writes drain in blanking.
// Revision : 1.0
// ============================================================================
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int H_DISP     = c_H_DISP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [c_COORD_W-1:0]  i_x,
    input  logic [c_COORD_W-1:0]  i_y,
    input  logic                  i_disp_en,
    input  logic                  i_wr_valid,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    output logic                  o_wr_ready,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic                  o_sram_we_n,
    output logic [DATA_W-1:0]     o_sram_wdata,
    input  logic [DATA_W-1:0]     i_sram_rdata,
    output logic [DATA_W-1:0]     o_pix,
    output logic                  o_pix_valid
);

    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ENT_W  = ADDR_W + DATA_W;
    localparam int c_PROD_W = 2 * c_COORD_W;

    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_CNT_W-1:0]  w_fifo_count;
    logic [c_ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic [c_PROD_W-1:0] w_lin_addr;
    logic [ADDR_W-1:0]   w_rd_addr;

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                sram_we_n_q, sram_we_n_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0]   pix_q, pix_d;
    logic                pix_valid_q, pix_valid_d;

    assign o_wr_ready = (w_fifo_count < c_CNT_W'(FIFO_DEPTH));
    assign w_push     = i_wr_valid && !w_fifo_full;
    assign w_pop      = (state_d == ST_WRITE);

    vga_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({i_wr_addr, i_wr_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_head_addr = w_head[c_ENT_W-1 -: ADDR_W];
    assign w_head_data = w_head[DATA_W-1:0];

    // 640 = 512 + 128, so the linear address needs only two shifts and adds.
    generate
        if (H_DISP == 640) begin : g_addr_shift
            assign w_lin_addr = ({{c_COORD_W{1'b0}}, i_y} << 9)
                              + ({{c_COORD_W{1'b0}}, i_y} << 7)
                              + {{c_COORD_W{1'b0}}, i_x};
        end else begin : g_addr_mul
            assign w_lin_addr = c_PROD_W'(int'(i_y) * H_DISP + int'(i_x));
        end
    endgenerate

    assign w_rd_addr = ADDR_W'(w_lin_addr);

    always_comb begin
        state_d      = ST_IDLE;
        sram_addr_d  = sram_addr_q;
        sram_we_n_d  = 1'b1;
        sram_wdata_d = sram_wdata_q;
        if (i_disp_en) begin
            state_d     = ST_READ;
            sram_addr_d = w_rd_addr;
        end else if (!w_fifo_empty) begin
            state_d      = ST_WRITE;
            sram_addr_d  = w_head_addr;
            sram_wdata_d = w_head_data;
            sram_we_n_d  = 1'b0;
        end
        pix_d       = i_sram_rdata;
        // The registered READ state is i_disp_en delayed once; one more flop makes two.
        pix_valid_d = (state_q == ST_READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sram_addr_q  <= '0;
            sram_we_n_q  <= 1'b1;
            sram_wdata_q <= '0;
            pix_q        <= '0;
            pix_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_wdata_q <= sram_wdata_d;
            pix_q        <= pix_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    assign o_sram_addr  = sram_addr_q;
    assign o_sram_we_n  = sram_we_n_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_pix        = pix_q;
    assign o_pix_valid  = pix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_mem_arbiter
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_vga_mem_arbiter;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    x = '0;
    logic [9:0]    y = '0;
    logic          disp_en = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] pix;
    logic          pix_valid;

    always #20 clk = ~clk;

    vga_mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .H_DISP     (640)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_disp_en    (disp_en),
        .i_wr_valid   (wr_valid),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .o_sram_addr  (sram_addr),
        .o_sram_we_n  (sram_we_n),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata),
        .o_pix        (pix),
        .o_pix_valid  (pix_valid)
    );

    // Asynchronous SRAM: contents are a fixed function of the address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h5C3};
    endfunction

    assign sram_rdata = pat(sram_addr);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we_n;
    logic [DW-1:0] m_pix;
    logic          m_valid;
    logic          m_en1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_addr  = '0;
        m_wdata = '0;
        m_we_n  = 1'b1;
        m_pix   = '0;
        m_valid = 1'b0;
        m_en1   = 1'b0;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        logic acc;
        ent_t e;
        acc     = wr_valid && (mq.size() < DEPTH);
        m_pix   = pat(m_addr);
        m_valid = m_en1;
        m_en1   = disp_en;
        m_we_n  = 1'b1;
        if (disp_en) begin
            m_addr = AW'(int'(y) * 640 + int'(x));
        end else if (mq.size() > 0) begin
            e       = mq.pop_front();
            m_addr  = e.a;
            m_wdata = e.d;
            m_we_n  = 1'b0;
        end
        if (acc) begin
            e.a = wr_addr;
            e.d = wr_data;
            mq.push_back(e);
        end
    endtask

    task automatic compare();
        check("ready", wr_ready, mq.size() < DEPTH);
        check("we_n", sram_we_n, m_we_n);
        check("addr", sram_addr, m_addr);
        if (!m_we_n) check("wdata", sram_wdata, m_wdata);
        check("pix_valid", pix_valid, m_valid);
        if (m_valid) check("pix", pix, m_pix);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set_in(input logic en, input int cx, input int cy,
                          input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        disp_en  = en;
        x        = 10'(cx);
        y        = 10'(cy);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_we_n", sram_we_n, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_pix", pix, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_count", dut.u_fifo.o_count, 0);
        repeat (n) @(negedge clk);
        check("rst_ready", wr_ready, 1);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(2);
        tick();

        // Single display read: (5,2) -> 1285, pixel two cycles later.
        set_in(1, 5, 2, 0, '0, '0);
        tick();
        check("rd_addr_1285", sram_addr, 1285);
        check("rd_we_n", sram_we_n, 1);
        set_in(1, 6, 2, 0, '0, '0);
        tick();
        check("rd_pix_1285", pix, pat(20'd1285));
        check("rd_pix_valid", pix_valid, 1);

        // Fill the buffer during display; nothing may reach the SRAM.
        for (int k = 0; k < 4; k++) begin
            set_in(1, $urandom_range(639, 0), $urandom_range(479, 0), 1, AW'(20'h100 + k), DW'(16'hA000 + k));
            tick();
            check("disp_no_write", sram_we_n, 1);
        end
        check("full_not_ready", wr_ready, 0);
        set_in(1, 7, 3, 1, 20'hFFFFF, 16'hBAD0);
        tick();
        check("full_still_not_ready", wr_ready, 0);

        // Blank with a full buffer: four back-to-back writes in push order, then idle.
        set_in(0, 0, 0, 0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_we_n", sram_we_n, 0);
            check("drain_addr", sram_addr, 32'h100 + k);
            check("drain_data", sram_wdata, 32'hA000 + k);
        end
        tick();
        check("idle_we_n", sram_we_n, 1);
        check("idle_addr_hold", sram_addr, 32'h103);

        // Simultaneous push and pop at count 2.
        for (int k = 0; k < 2; k++) begin
            set_in(1, 10, 10, 1, AW'(20'h200 + k), DW'(16'hC000 + k));
            tick();
        end
        for (int k = 2; k < 5; k++) begin
            set_in(0, 0, 0, 1, AW'(20'h200 + k), DW'(16'hC000 + k));
            tick();
            check("pp_count", dut.u_fifo.o_count, 2);
            check("pp_data", sram_wdata, 32'hC000 + k - 2);
        end
        set_in(0, 0, 0, 0, '0, '0);
        for (int k = 3; k < 5; k++) begin
            tick();
            check("pp_tail_data", sram_wdata, 32'hC000 + k);
        end

        // Display returns mid-drain with two entries left.
        for (int k = 0; k < 4; k++) begin
            set_in(1, 20, 20, 1, AW'(20'h300 + k), DW'(16'hD000 + k));
            tick();
        end
        set_in(0, 0, 0, 0, '0, '0);
        tick();
        tick();
        check("mid_inflight_data", sram_wdata, 32'hD001);
        check("mid_inflight_we_n", sram_we_n, 0);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 30 + k, 40, 0, '0, '0);
            tick();
            check("mid_read_we_n", sram_we_n, 1);
            check("mid_retained", dut.u_fifo.o_count, 2);
        end
        set_in(0, 0, 0, 0, '0, '0);
        tick();
        check("resume_data0", sram_wdata, 32'hD002);
        tick();
        check("resume_data1", sram_wdata, 32'hD003);
        tick();
        check("resume_idle", sram_we_n, 1);

        // Reset with three buffered entries.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 50, 50, 1, AW'(20'h400 + k), DW'(16'hE000 + k));
            tick();
        end
        set_in(0, 0, 0, 0, '0, '0);
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_write", sram_we_n, 1);
        end

        // Random traffic with bursty display enable.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15, 0) == 0) disp_en = ~disp_en;
            x        = 10'($urandom_range(639, 0));
            y        = 10'($urandom_range(479, 0));
            wr_valid = ($urandom_range(2, 0) != 0);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            if (c == 1500) begin
                do_reset(1);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
